// File: rtl/ddr_arbiter.sv
// ddr_arbiter: round-robin burst arbiter sharing the DDRAM port between two masters
module ddr_arbiter (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        p0_rd,
  input  logic        p0_wr,
  input  logic [31:0] p0_addr,
  input  logic [7:0]  p0_burst,
  input  logic [63:0] p0_din,
  input  logic [7:0]  p0_mask,
  output logic        p0_wait,
  output logic        p0_valid,
  output logic [63:0] p0_dout,
  input  logic        p1_rd,
  input  logic        p1_wr,
  input  logic [31:0] p1_addr,
  input  logic [7:0]  p1_burst,
  input  logic [63:0] p1_din,
  input  logic [7:0]  p1_mask,
  output logic        p1_wait,
  output logic        p1_valid,
  output logic [63:0] p1_dout,
  input  logic        DDRAM_BUSY,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic        DDRAM_WE,
  output logic [28:0] DDRAM_ADDR,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE
);
  typedef enum logic [1:0] {IDLE, GRANT, READ, WRITE} state_t;
  state_t state, state_nx;
  logic owner, owner_nx, last, last_nx;
  logic [7:0] cnt, cnt_nx, blen, blen_nx;
  logic rd, wr, act, own_wait, rbeat;
  logic [31:0] addr;
  logic [7:0] burst, mask, bmax;
  logic [63:0] din;
  always_comb begin
    rd    = owner ? p1_rd    : p0_rd;
    wr    = owner ? p1_wr    : p0_wr;
    addr  = owner ? p1_addr  : p0_addr;
    burst = owner ? p1_burst : p0_burst;
    din   = owner ? p1_din   : p0_din;
    mask  = owner ? p1_mask  : p0_mask;
    bmax  = (burst == 8'd0) ? 8'd1 : burst;
    act   = (state == GRANT) || (state == WRITE);
    rbeat = (state == READ) && DDRAM_DOUT_READY;
  end
  always_ff @(posedge clk_sys or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= 8'd0;
      blen  <= 8'd0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
      blen  <= blen_nx;
    end
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    cnt_nx   = cnt;
    blen_nx  = blen;
    case (state)
      IDLE:
        if ((p0_rd | p0_wr) || (p1_rd | p1_wr)) begin
          state_nx = GRANT;
          owner_nx = ((p0_rd | p0_wr) && (p1_rd | p1_wr)) ? ~last : (p1_rd | p1_wr);
        end
      GRANT:
        if (rd && !DDRAM_BUSY) begin
          cnt_nx   = bmax;
          state_nx = READ;
        end else if (wr && !DDRAM_BUSY) begin
          cnt_nx   = bmax - 8'd1;
          blen_nx  = burst;
          state_nx = (bmax == 8'd1) ? IDLE : WRITE;
          last_nx  = (bmax == 8'd1) ? owner : last;
        end else if (!rd && !wr)
          state_nx = IDLE;
      READ:
        if (DDRAM_DOUT_READY) begin
          cnt_nx   = cnt - 8'd1;
          state_nx = (cnt == 8'd1) ? IDLE : READ;
          last_nx  = (cnt == 8'd1) ? owner : last;
        end
      WRITE:
        if (wr && !DDRAM_BUSY) begin
          cnt_nx   = cnt - 8'd1;
          state_nx = (cnt == 8'd1) ? IDLE : WRITE;
          last_nx  = (cnt == 8'd1) ? owner : last;
        end
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    DDRAM_RD       = (state == GRANT) && rd;
    DDRAM_WE       = ((state == GRANT) && wr && !rd) || ((state == WRITE) && wr);
    DDRAM_ADDR     = act ? addr[31:3] : 29'd0;
    DDRAM_BURSTCNT = (state == GRANT) ? burst : (state == WRITE) ? blen : 8'd0;
    DDRAM_DIN      = act ? din : 64'd0;
    DDRAM_BE       = act ? mask : 8'd0;
    own_wait       = act ? DDRAM_BUSY : 1'b1;
    p0_wait        = owner ? 1'b1 : own_wait;
    p1_wait        = owner ? own_wait : 1'b1;
    p0_valid       = rbeat && !owner;
    p1_valid       = rbeat && owner;
    p0_dout        = DDRAM_DOUT;
    p1_dout        = DDRAM_DOUT;
  end
endmodule

// File: doc/ddr_arbiter.md
# ddr_arbiter

Two-port arbiter that shares the single MiSTer DDRAM Avalon-style port between two masters: port 0 (ROM download/upload writer) and port 1 (sprite/system frame-buffer engine). It sits between the core's memory clients and the top-level DDRAM_* pins, in the clk_sys domain. It grants the port for whole bursts, using round-robin priority, and routes read data back only to the owning master.

## Interface
- No parameters. Data width is fixed at 64 bits, byte mask at 8 bits, and burst count at 8 bits.
- clk_sys  in  1  system clock; DDRAM_CLK is driven from the same clock at top level
- RESET  in  1  asynchronous, active-high reset
- pN_rd  in  1  read request, port N (N = 0, 1)
- pN_wr  in  1  write request/beat, port N
- pN_addr  in  32  byte address; bits [2:0] are ignored
- pN_burst  in  8  burst length in 64-bit words; 0 is treated as 1
- pN_din  in  64  write data
- pN_mask  in  8  byte enables
- pN_wait  out  1  wait request to port N
- pN_valid  out  1  read beat valid to port N
- pN_dout  out  64  read data (shared fan-out of DDRAM_DOUT)
- DDRAM_BUSY  in  1  wait request from DDR
- DDRAM_DOUT  in  64  read data
- DDRAM_DOUT_READY  in  1  read beat valid
- DDRAM_RD, DDRAM_WE  out  1  command strobes
- DDRAM_ADDR  out  29  word address = pN_addr[31:3]
- DDRAM_BURSTCNT  out  8  burst count
- DDRAM_DIN  out  64  write data
- DDRAM_BE  out  8  byte enables

## Operation
- **States:** IDLE, GRANT, READ, WRITE. State reg, owner reg (0/1), last reg (last owner), beat counter (8 bits).
- **IDLE:**
  - Sample requests: req_N = pN_rd | pN_wr.
  - If both ports request, choose the port ≠ last. Otherwise choose the single requester.
  - On a choice, register owner and go to GRANT.
- **GRANT:**
  - Owner's rd, wr, addr, burst, din and mask pass combinationally to DDRAM_*.
  - pN_wait(owner) = DDRAM_BUSY.
  - On accepted read (DDRAM_RD & !BUSY): load counter = max(burst, 1) and go to READ.
  - On accepted write: load counter = max(burst, 1) − 1. If the result is 0, go to IDLE; else go to WRITE.
  - If the owner deasserts both rd and wr before acceptance, return to IDLE with no command issued.
- **READ:**
  - DDRAM_RD = 0. The owner's wait stays 1.
  - Each DDRAM_DOUT_READY asserts pN_valid(owner) and decrements the counter.
  - When the counter reaches 1 and a beat arrives, go to IDLE and set last = owner.
- **WRITE:**
  - Owner's wr/din/mask pass through; DDRAM_BURSTCNT is held at the latched burst.
  - Each WE & !BUSY decrements the counter; the beat at counter 1 returns to IDLE and sets last = owner.
  - Address is ignored after the first beat (DDR semantics).
- **Non-owner:** pN_wait = 1 and pN_valid = 0 always.
- **Output gating:** DDRAM_RD and DDRAM_WE are 0 in IDLE. When rd and wr are asserted together, rd takes precedence and WE is masked.
- **Last-owner update:** the GRANT abort path does not update last.

## Timing
- **Reset values:** state IDLE, owner 0, last 1 (port 0 wins the first tie), counter 0. All DDRAM_* outputs 0. p0_wait = p1_wait = 1, pN_valid = 0.
- **Arbitration latency:** a request in IDLE at cycle t reaches DDRAM at t+1. The earliest acceptance is t+1, if BUSY = 0.
- **Idle gap:** minimum 1 idle cycle between bursts (the return to IDLE), so back-to-back grants have a 1-cycle bubble.
- **Read data:** DOUT_READY to pN_valid is combinational, with zero added latency.
- **Asynchronous reset mid-burst:** the FSM aborts immediately. DDR-side cleanup is not required because RESET also resets the DDR client.
- **Spurious read data:** a DOUT_READY arriving in IDLE or GRANT is ignored (no pN_valid).
- **Counter width:** 8 bits; burst 255 is legal.

## Test plan
- **Reset:** assert RESET mid-WRITE (counter 3) → state IDLE, DDRAM_WE = 0, p0_wait = p1_wait = 1 within the same cycle.
- **Single read:**
  - Stimulus: p1_rd with addr 0x0000_1008, burst 4, BUSY = 0.
  - Required: DDRAM_ADDR = 0x201 and BURSTCNT = 4 one cycle later.
  - Required: 4 DOUT_READY beats give p1_valid ×4, p0_valid = 0, then IDLE.
- **Tie round-robin:** p0_wr and p1_rd both held continuously, each with burst 1 → grants alternate 0, 1, 0, 1. Each grant is separated by exactly 1 idle cycle.
- **BUSY stall on write:**
  - Stimulus: p0 write with burst 3, BUSY high for the 2nd beat for 5 cycles.
  - Required: p0_wait follows BUSY, exactly 3 WE & !BUSY beats occur, and p1 stays waited throughout.
- **Burst 0 and read/write conflict:**
  - p0_rd with burst 0 → BURSTCNT passes 0 and 1 beat completes the read.
  - Owner asserting rd & wr together → DDRAM_RD = 1 and DDRAM_WE = 0.
- **Abort in GRANT:** p1_rd drops while BUSY = 1 → return to IDLE, no DDRAM_RD accepted, last unchanged.
